// File: rtl/safe_pkg.sv
// safe_pkg: shared types, reset combination and button-decode helpers for the safecrack supervisor.
//   state_t            one-hot controller state (ARMED, AUTH, PROG, LOCKOUT)
//   digit_t            one combination digit (button index 0..2)
//   DEFAULT_CODE       reset combination, digit k at bits [2k+1:2k]
//   digit_from_onehot  button index of a one-hot button vector
//   is_onehot3         exactly one button pressed
package safe_pkg;
  typedef enum logic [3:0] {
    ARMED   = 4'b0001,
    AUTH    = 4'b0010,
    PROG    = 4'b0100,
    LOCKOUT = 4'b1000
  } state_t;
  typedef logic [1:0] digit_t;
  localparam logic [5:0] DEFAULT_CODE = 6'b10_01_00;
  function automatic digit_t digit_from_onehot(input logic [2:0] b);
    return b[2] ? 2'd2 : (b[1] ? 2'd1 : 2'd0);
  endfunction
  function automatic logic is_onehot3(input logic [2:0] b);
    return (b == 3'b001) || (b == 3'b010) || (b == 3'b100);
  endfunction
endpackage

// File: rtl/safe_timer.sv
// safe_timer: loadable down-counter that stops at zero.
//   clk, rstn  clock, asynchronous active-low reset (count cleared)
//   i_load     load i_value this cycle (overrides counting)
//   i_value    WIDTH-bit load value
//   o_zero     count is zero
module safe_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);
  logic [WIDTH-1:0] r_cnt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (r_cnt != '0) r_cnt <= r_cnt - WIDTH'(1);
  end
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/safe_code_ctrl.sv
// safe_code_ctrl: supervisory controller owning the combination, failure count, lockout and code programming.
//   clk, rstn      clock, asynchronous active-low reset
//   i_btn_evt      per-button one-cycle press pulses
//   i_prog_req     request a programming session (honoured in AUTH)
//   i_chk_ok       checker reports correct combination
//   i_chk_fail     checker reports wrong digit
//   o_chk_en       checker may accept digits (ARMED)
//   o_code         active combination, digit 0 in the low bits
//   o_locked       lockout in progress
//   o_prog_active  AUTH or PROG in progress
//   o_prog_done    one-cycle pulse when a new code is committed
//   o_fail_cnt     consecutive failure count
// Build option SAFE_LOCK_ESCALATE_EN: each lockout doubles in length (up to 4x), reset by a good code.
module safe_code_ctrl
  import safe_pkg::*;
#(
  parameter int                      CODE_LEN     = 3,
  parameter int                      MAX_FAILS    = 3,
  parameter int                      LOCK_CYCLES  = 500_000_000,
  parameter int                      PROG_TIMEOUT = 500_000_000,
  parameter logic [2*CODE_LEN-1:0]   DEFAULT_CODE = safe_pkg::DEFAULT_CODE
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [2:0]                     i_btn_evt,
  input  logic                           i_prog_req,
  input  logic                           i_chk_ok,
  input  logic                           i_chk_fail,
  output logic                           o_chk_en,
  output logic [2*CODE_LEN-1:0]          o_code,
  output logic                           o_locked,
  output logic                           o_prog_active,
  output logic                           o_prog_done,
  output logic [$clog2(MAX_FAILS+1)-1:0] o_fail_cnt
);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
`ifdef SAFE_LOCK_ESCALATE_EN
  localparam longint LOCK_MAX = 4 * longint'(LOCK_CYCLES);
`else
  localparam longint LOCK_MAX = longint'(LOCK_CYCLES);
`endif
  localparam longint T_MAX = (LOCK_MAX > longint'(PROG_TIMEOUT)) ? LOCK_MAX : longint'(PROG_TIMEOUT);
  localparam int TW = (T_MAX < 2) ? 1 : $clog2(T_MAX);

  state_t                  r_state, w_next;
  logic [FW-1:0]           r_fail, w_fail_nxt, w_fail_inc;
  logic [IW-1:0]           r_idx, w_idx_nxt;
  digit_t [CODE_LEN-1:0]   r_shadow, w_shadow_nxt;
  logic [2*CODE_LEN-1:0]   r_code, w_code_nxt;
  logic                    r_done, w_done_nxt;
  logic                    w_tload, w_tzero;
  logic [TW-1:0]           w_tval, w_lock_val;
`ifdef SAFE_LOCK_ESCALATE_EN
  logic [1:0]              r_lvl, w_lvl_nxt;
  // Length uses the level held at entry; the level bumps on the same edge.
  assign w_lock_val = TW'((longint'(LOCK_CYCLES) << r_lvl) - longint'(1));
`else
  assign w_lock_val = TW'(LOCK_CYCLES - 1);
`endif
  assign w_fail_inc = r_fail + FW'(1);

  safe_timer #(.WIDTH(TW)) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_tload),
    .i_value (w_tval),
    .o_zero  (w_tzero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ARMED;
      r_fail   <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_code   <= DEFAULT_CODE;
      r_done   <= 1'b0;
`ifdef SAFE_LOCK_ESCALATE_EN
      r_lvl    <= 2'd0;
`endif
    end else begin
      r_state  <= w_next;
      r_fail   <= w_fail_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
      r_code   <= w_code_nxt;
      r_done   <= w_done_nxt;
`ifdef SAFE_LOCK_ESCALATE_EN
      r_lvl    <= w_lvl_nxt;
`endif
    end
  end

  always_comb begin
    w_next       = r_state;
    w_tload      = 1'b0;
    w_tval       = '0;
    w_fail_nxt   = r_fail;
    w_idx_nxt    = r_idx;
    w_shadow_nxt = r_shadow;
    w_code_nxt   = r_code;
    w_done_nxt   = 1'b0;
`ifdef SAFE_LOCK_ESCALATE_EN
    w_lvl_nxt    = r_lvl;
`endif
    case (r_state)
      ARMED: begin
        // A simultaneous ok/fail pair counts as a failure only.
        if (i_chk_fail) begin
          w_fail_nxt = w_fail_inc;
          if (w_fail_inc == FW'(MAX_FAILS)) begin
            w_next  = LOCKOUT;
            w_tload = 1'b1;
            w_tval  = w_lock_val;
`ifdef SAFE_LOCK_ESCALATE_EN
            w_lvl_nxt = (r_lvl == 2'd2) ? 2'd2 : r_lvl + 2'd1;
`endif
          end
        end else if (i_chk_ok) begin
          w_fail_nxt = '0;
          w_next     = AUTH;
          w_tload    = 1'b1;
          w_tval     = TW'(PROG_TIMEOUT - 1);
`ifdef SAFE_LOCK_ESCALATE_EN
          w_lvl_nxt  = 2'd0;
`endif
        end
      end
      AUTH: begin
        if (i_prog_req) begin
          w_next    = PROG;
          w_idx_nxt = '0;
          w_tload   = 1'b1;
          w_tval    = TW'(PROG_TIMEOUT - 1);
        end else if (w_tzero) begin
          w_next = ARMED;
        end
      end
      PROG: begin
        if (is_onehot3(i_btn_evt)) begin
          w_shadow_nxt[r_idx] = digit_from_onehot(i_btn_evt);
          if (r_idx == IW'(CODE_LEN - 1)) begin
            w_code_nxt = w_shadow_nxt;
            w_done_nxt = 1'b1;
            w_next     = ARMED;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
            w_tload   = 1'b1;
            w_tval    = TW'(PROG_TIMEOUT - 1);
          end
        end else if (w_tzero) begin
          w_next = ARMED;
        end
      end
      LOCKOUT: begin
        if (w_tzero) begin
          w_next     = ARMED;
          w_fail_nxt = '0;
        end
      end
      default: w_next = ARMED;
    endcase
  end

  always_comb begin
    o_chk_en      = (r_state == ARMED);
    o_locked      = (r_state == LOCKOUT);
    o_prog_active = (r_state == AUTH) || (r_state == PROG);
    o_prog_done   = r_done;
    o_code        = r_code;
    o_fail_cnt    = r_fail;
  end
endmodule

// File: tb/tb_safe_code_ctrl.sv
// tb_safe_code_ctrl: randomized and directed checks of safe_code_ctrl against a behavioural model.
module tb_safe_code_ctrl;
  localparam int LOCK = 8, PTO = 16, MAXF = 3;
  localparam logic [5:0] DEF = 6'b10_01_00;
  logic clk = 1'b0, rstn = 1'b0;
  logic [2:0] btn = '0;
  logic prog = 1'b0, ok = 1'b0, fail = 1'b0;
  logic chk_en, locked, prog_active, prog_done;
  logic [5:0] code;
  logic [1:0] fail_cnt;
  int vecs = 0, errs = 0;

  safe_code_ctrl #(.CODE_LEN(3), .MAX_FAILS(MAXF), .LOCK_CYCLES(LOCK), .PROG_TIMEOUT(PTO)) dut (
    .clk(clk), .rstn(rstn), .i_btn_evt(btn), .i_prog_req(prog), .i_chk_ok(ok), .i_chk_fail(fail),
    .o_chk_en(chk_en), .o_code(code), .o_locked(locked), .o_prog_active(prog_active),
    .o_prog_done(prog_done), .o_fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  wire [11:0] obs = {chk_en, locked, prog_active, prog_done, fail_cnt, code};

  // Model: mode 0 armed, 1 awaiting prog request, 2 entering digits, 3 locked out.
  // m_left = clock edges still to spend in the timed mode.
  int m_mode, m_left, m_fails, m_lvl;
  logic [5:0] m_code;
  bit m_done;
  int m_digits[$];

  function automatic void m_reset();
    m_mode = 0; m_left = 0; m_fails = 0; m_lvl = 0; m_code = DEF; m_done = 0;
    m_digits.delete();
  endfunction

  function automatic void m_step(logic [2:0] b, logic p, logic o, logic f);
    int d;
    m_done = 0;
    case (m_mode)
      0: if (f) begin
           m_fails++;
           if (m_fails == MAXF) begin
             m_mode = 3;
`ifdef SAFE_LOCK_ESCALATE_EN
             m_left = LOCK * (1 << m_lvl);
             m_lvl = (m_lvl < 2) ? m_lvl + 1 : 2;
`else
             m_left = LOCK;
`endif
           end
         end else if (o) begin
           m_fails = 0; m_lvl = 0; m_mode = 1; m_left = PTO;
         end
      1: if (p) begin
           m_mode = 2; m_left = PTO; m_digits.delete();
         end else begin
           m_left--;
           if (m_left == 0) m_mode = 0;
         end
      2: if ($countones(b) == 1) begin
           d = 0;
           for (int k = 0; k < 3; k++) if (b[k]) d = k;
           m_digits.push_back(d);
           if (m_digits.size() == 3) begin
             m_code = 6'(m_digits[0] + m_digits[1] * 4 + m_digits[2] * 16);
             m_done = 1; m_mode = 0;
           end else m_left = PTO;
         end else begin
           m_left--;
           if (m_left == 0) m_mode = 0;
         end
      default: begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; m_fails = 0; end
      end
    endcase
  endfunction

  function automatic logic [11:0] m_vec();
    return {m_mode == 0, m_mode == 3, m_mode == 1 || m_mode == 2, m_done, 2'(m_fails), m_code};
  endfunction

  task automatic cyc(input logic [2:0] b, input logic p, input logic o, input logic f);
    btn = b; prog = p; ok = o; fail = f;
    @(posedge clk);
    m_step(b, p, o, f);
    #1;
    btn = '0; prog = 0; ok = 0; fail = 0;
  endtask

  task automatic run_lockout(output int n);
    n = 0;
    while (locked && n < 100) begin n++; cyc(3'b000, 0, 0, 0); end
  endtask

  task automatic test_reset();
    rstn = 0; m_reset();
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (obs !== 12'b1000_00_100100) begin errs++; $display("FAIL reset_hold: dut=%b want=%b", obs, 12'b1000_00_100100); end
    rstn = 1;
    cyc(3'b000, 0, 0, 0);
    vecs++;
    if (obs !== m_vec()) begin errs++; $display("FAIL reset_release: dut=%b model=%b", obs, m_vec()); end
  endtask

  task automatic test_lockout();
    int n;
    for (int i = 0; i < 3; i++) begin
      cyc(3'b000, 0, 0, 1);
      vecs++;
      if (obs !== m_vec()) begin errs++; $display("FAIL lockout_fail%0d: dut=%b model=%b", i, obs, m_vec()); end
    end
    n = 0;
    while (locked && n < 100) begin
      n++;
      cyc(3'b000, 0, 0, 0);
      vecs++;
      if (obs !== m_vec()) begin errs++; $display("FAIL lockout_cyc%0d: dut=%b model=%b", n, obs, m_vec()); end
    end
    vecs++;
    if (n !== LOCK) begin errs++; $display("FAIL lockout_len: dut=%0d want=%0d", n, LOCK); end
    vecs++;
    if ({chk_en, fail_cnt} !== 3'b100) begin errs++; $display("FAIL lockout_exit: dut=%b want=100", {chk_en, fail_cnt}); end
  endtask

  task automatic test_program();
    logic [2:0] seq [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b010};
    for (int i = 0; i < 5; i++) begin
      cyc(seq[i], i == 1, i == 0, 0);
      vecs++;
      if (obs !== m_vec()) begin errs++; $display("FAIL program_step%0d: dut=%b model=%b", i, obs, m_vec()); end
    end
    vecs++;
    if ({prog_done, code} !== 7'b1_01_00_10) begin errs++; $display("FAIL program_commit: dut=%b want=%b", {prog_done, code}, 7'b1_01_00_10); end
    cyc(3'b000, 0, 0, 0);
    vecs++;
    if (prog_done !== 1'b0) begin errs++; $display("FAIL program_done_pulse: dut=%b want=0", prog_done); end
  endtask

  task automatic test_prog_timeout();
    cyc(3'b000, 0, 1, 0);
    cyc(3'b000, 1, 0, 0);
    cyc(3'b011, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      cyc(3'b000, 0, 0, 0);
      vecs++;
      if (obs !== m_vec()) begin errs++; $display("FAIL prog_timeout_cyc%0d: dut=%b model=%b", i, obs, m_vec()); end
    end
    vecs++;
    if ({chk_en, prog_active, code} !== 8'b10_01_00_10) begin errs++; $display("FAIL prog_timeout_end: dut=%b want=%b", {chk_en, prog_active, code}, 8'b10_01_00_10); end
  endtask

  task automatic test_ok_fail_same();
    int n;
    cyc(3'b000, 0, 0, 1);
    cyc(3'b000, 0, 0, 1);
    cyc(3'b000, 0, 1, 1);
    vecs++;
    if ({locked, prog_active} !== 2'b10 || obs !== m_vec()) begin errs++; $display("FAIL ok_fail_same: dut=%b model=%b", obs, m_vec()); end
    run_lockout(n);
    vecs++;
    if (obs !== m_vec()) begin errs++; $display("FAIL ok_fail_same_exit: dut=%b model=%b", obs, m_vec()); end
  endtask

  task automatic test_reset_mid_lockout();
    for (int i = 0; i < 3; i++) cyc(3'b000, 0, 0, 1);
    repeat (3) cyc(3'b000, 0, 0, 0);
    rstn = 0; m_reset();
    #1;
    vecs++;
    if ({locked, chk_en, code} !== {2'b01, DEF}) begin errs++; $display("FAIL reset_mid_async: dut=%b want=%b", {locked, chk_en, code}, {2'b01, DEF}); end
    @(posedge clk); #1;
    rstn = 1;
    cyc(3'b000, 0, 0, 0);
    vecs++;
    if (obs !== m_vec()) begin errs++; $display("FAIL reset_mid_release: dut=%b model=%b", obs, m_vec()); end
  endtask

`ifdef SAFE_LOCK_ESCALATE_EN
  task automatic test_escalate();
    int n;
    int want [3] = '{LOCK, 2 * LOCK, LOCK};
    for (int r = 0; r < 3; r++) begin
      if (r == 2) cyc(3'b000, 0, 1, 0);
      repeat (3) cyc(3'b000, 0, 0, 1);
      run_lockout(n);
      vecs++;
      if (n !== want[r]) begin errs++; $display("FAIL escalate_len%0d: dut=%0d want=%0d", r, n, want[r]); end
    end
  endtask
`endif

  task automatic test_random();
    logic [2:0] b;
    logic p, o, f;
    for (int i = 0; i < 600; i++) begin
      b = ($urandom % 2 == 1) ? (3'b001 << ($urandom % 3)) : 3'($urandom);
      p = ($urandom % 4 == 0);
      o = ($urandom % 6 == 0);
      f = ($urandom % 8 == 0);
      cyc(b, p, o, f);
      vecs++;
      if (obs !== m_vec()) begin errs++; $display("FAIL random_cyc%0d: dut=%b model=%b", i, obs, m_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_lockout();
    test_program();
    test_prog_timeout();
    test_ok_fail_same();
    test_reset_mid_lockout();
`ifdef SAFE_LOCK_ESCALATE_EN
    test_escalate();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
